// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encoding, opcode/funct
// values and the datapath select encodings driven by the control FSM.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_IR       = 5'd2,
        S_DECODE   = 5'd3,
        S_R_ALU    = 5'd4,
        S_R_WB     = 5'd5,
        S_SH_LD    = 5'd6,
        S_SH_OP    = 5'd7,
        S_SH_WB    = 5'd8,
        S_ADDI     = 5'd9,
        S_I_WB     = 5'd10,
        S_MADDR    = 5'd11,
        S_LW_WAIT  = 5'd12,
        S_LW_WB    = 5'd13,
        S_SW       = 5'd14,
        S_BRANCH   = 5'd15,
        S_JUMP     = 5'd16,
        S_JR       = 5'd17,
        S_RTE      = 5'd18,
        S_HALT     = 5'd19,
        S_EXC_EPC  = 5'd20,
        S_EXC_WAIT = 5'd21,
        S_EXC_PC   = 5'd22
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_RTE   = 6'h13;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] ALU_PASSA = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;

    localparam logic [2:0] SH_NOP  = 3'd0;
    localparam logic [2:0] SH_LOAD = 3'd1;
    localparam logic [2:0] SH_SLL  = 3'd2;
    localparam logic [2:0] SH_SRL  = 3'd3;

    localparam logic [3:0] SRCB_B        = 4'd0;
    localparam logic [3:0] SRCB_FOUR     = 4'd1;
    localparam logic [3:0] SRCB_SEXT     = 4'd2;
    localparam logic [3:0] SRCB_SEXT_SH2 = 4'd3;

    localparam logic [3:0] PCS_ALU_RESULT = 4'd0;
    localparam logic [3:0] PCS_ALU_OUT    = 4'd1;
    localparam logic [3:0] PCS_JUMP       = 4'd2;
    localparam logic [3:0] PCS_EPC        = 4'd3;
    localparam logic [3:0] PCS_VECTOR     = 4'd4;

    localparam logic [3:0] EXC_NONE        = 4'd0;
    localparam logic [3:0] EXC_OPCODE_CODE = 4'd1;
    localparam logic [3:0] EXC_OVF_CODE    = 4'd2;

    // States that park on memory and share the wait counter.
    function automatic logic is_wait_state(input state_t s);
        return s inside {S_FETCH, S_LW_WAIT, S_EXC_WAIT};
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control interface between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if;

    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       Overflow;
    logic       Zero;

    logic       PCwrite;
    logic       MemWrite;
    logic       MemRead;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemToReg;
    logic       RegDest;
    logic       AluSrcA;
    logic       EPCWrite;
    logic       IorD;
    logic       WriteSrc;
    logic [2:0] ALUControl;
    logic [2:0] ShiftControl;
    logic [3:0] AluSrcB;
    logic [3:0] PCSource;
    logic [3:0] Exception;
    logic [4:0] state_dbg;

    modport master (
        input  OPCODE, FUNCT, Overflow, Zero,
        output PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest,
               AluSrcA, EPCWrite, IorD, WriteSrc, ALUControl, ShiftControl,
               AluSrcB, PCSource, Exception, state_dbg
    );

    modport slave (
        output OPCODE, FUNCT, Overflow, Zero,
        input  PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest,
               AluSrcA, EPCWrite, IorD, WriteSrc, ALUControl, ShiftControl,
               AluSrcB, PCSource, Exception, state_dbg
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Memory latency counter: cleared by load, counts up and holds once MEM_WAIT cycles
// of the current wait state have elapsed (done is high in that final cycle).
module mem_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

    logic [2:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (!done) begin
            cnt_reg <= cnt_reg + 3'd1;
        end
    end

    assign done = (cnt_reg == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. Define OVERFLOW_EXC_EN to make
// add/sub/addi overflow trap to the exception vector instead of writing back.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int         MEM_WAIT       = 2,
    parameter logic [3:0] EXC_OPCODE_VEC = EXC_OPCODE_CODE,
    parameter logic [3:0] EXC_OVF_VEC    = EXC_OVF_CODE
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master ctrl
);

    state_t     state_reg, state_next;
    logic [3:0] code_reg, code_next;
    logic       wait_load;
    logic       wait_done;
    logic       ovf_trap;

    // Every wait state is entered from a non-wait state, so holding the counter
    // cleared outside the wait states gives a fresh count on each entry.
    assign wait_load = !is_wait_state(state_reg);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .done  (wait_done)
    );

`ifdef OVERFLOW_EXC_EN
    assign ovf_trap = ctrl.Overflow;
`else
    logic unused_overflow;
    assign unused_overflow = ctrl.Overflow;
    assign ovf_trap        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_RESET;
            code_reg  <= EXC_NONE;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
        end
    end

    assign ctrl.state_dbg = state_reg;

    always_comb begin
        state_next        = state_reg;
        code_next         = code_reg;
        ctrl.PCwrite      = 1'b0;
        ctrl.MemWrite     = 1'b0;
        ctrl.MemRead      = 1'b0;
        ctrl.IRWrite      = 1'b0;
        ctrl.RegWrite     = 1'b0;
        ctrl.MemToReg     = 1'b0;
        ctrl.RegDest      = 1'b0;
        ctrl.AluSrcA      = 1'b0;
        ctrl.EPCWrite     = 1'b0;
        ctrl.IorD         = 1'b0;
        ctrl.WriteSrc     = 1'b0;
        ctrl.ALUControl   = ALU_PASSA;
        ctrl.ShiftControl = SH_NOP;
        ctrl.AluSrcB      = SRCB_B;
        ctrl.PCSource     = PCS_ALU_RESULT;
        ctrl.Exception    = EXC_NONE;

        case (state_reg)
            S_RESET: state_next = S_FETCH;
            S_FETCH: if (wait_done) state_next = S_IR;
            S_IR: begin
                ctrl.IRWrite    = 1'b1;
                ctrl.AluSrcB    = SRCB_FOUR;
                ctrl.ALUControl = ALU_ADD;
                ctrl.PCwrite    = 1'b1;
                state_next      = S_DECODE;
            end
            S_DECODE: begin
                ctrl.AluSrcB    = SRCB_SEXT_SH2;
                ctrl.ALUControl = ALU_ADD;
                if (ctrl.OPCODE == OP_RTYPE) begin
                    case (ctrl.FUNCT)
                        FN_ADD, FN_SUB, FN_AND: state_next = S_R_ALU;
                        FN_SLL, FN_SRL:         state_next = S_SH_LD;
                        FN_JR:                  state_next = S_JR;
                        FN_RTE:                 state_next = S_RTE;
                        FN_BREAK:               state_next = S_HALT;
                        default: begin
                            state_next = S_EXC_EPC;
                            code_next  = EXC_OPCODE_VEC;
                        end
                    endcase
                end else begin
                    case (ctrl.OPCODE)
                        OP_ADDI:        state_next = S_ADDI;
                        OP_LW, OP_SW:   state_next = S_MADDR;
                        OP_BEQ, OP_BNE: state_next = S_BRANCH;
                        OP_J:           state_next = S_JUMP;
                        default: begin
                            state_next = S_EXC_EPC;
                            code_next  = EXC_OPCODE_VEC;
                        end
                    endcase
                end
            end
            S_R_ALU: begin
                ctrl.AluSrcA = 1'b1;
                case (ctrl.FUNCT)
                    FN_SUB:  ctrl.ALUControl = ALU_SUB;
                    FN_AND:  ctrl.ALUControl = ALU_AND;
                    default: ctrl.ALUControl = ALU_ADD;
                endcase
                // Logical and cannot overflow, so only add/sub may trap.
                if (ovf_trap && ctrl.FUNCT != FN_AND) begin
                    state_next = S_EXC_EPC;
                    code_next  = EXC_OVF_VEC;
                end else begin
                    state_next = S_R_WB;
                end
            end
            S_R_WB, S_SH_WB: begin
                ctrl.RegDest  = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.WriteSrc = (state_reg == S_SH_WB);
                state_next    = S_FETCH;
            end
            S_SH_LD: begin
                ctrl.ShiftControl = SH_LOAD;
                state_next        = S_SH_OP;
            end
            S_SH_OP: begin
                ctrl.ShiftControl = (ctrl.FUNCT == FN_SRL) ? SH_SRL : SH_SLL;
                state_next        = S_SH_WB;
            end
            S_ADDI, S_MADDR: begin
                ctrl.AluSrcA    = 1'b1;
                ctrl.AluSrcB    = SRCB_SEXT;
                ctrl.ALUControl = ALU_ADD;
                if (state_reg == S_MADDR) begin
                    state_next = (ctrl.OPCODE == OP_LW) ? S_LW_WAIT : S_SW;
                end else if (ovf_trap) begin
                    state_next = S_EXC_EPC;
                    code_next  = EXC_OVF_VEC;
                end else begin
                    state_next = S_I_WB;
                end
            end
            S_I_WB: begin
                ctrl.RegWrite = 1'b1;
                state_next    = S_FETCH;
            end
            S_LW_WAIT: begin
                ctrl.IorD    = 1'b1;
                ctrl.MemRead = wait_done;
                if (wait_done) state_next = S_LW_WB;
            end
            S_LW_WB: begin
                ctrl.MemToReg = 1'b1;
                ctrl.RegWrite = 1'b1;
                state_next    = S_FETCH;
            end
            S_SW: begin
                ctrl.IorD     = 1'b1;
                ctrl.MemWrite = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.AluSrcA    = 1'b1;
                ctrl.ALUControl = ALU_SUB;
                ctrl.PCSource   = PCS_ALU_OUT;
                ctrl.PCwrite    = (ctrl.OPCODE == OP_BEQ) ? ctrl.Zero : !ctrl.Zero;
                state_next      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.PCSource = PCS_JUMP;
                ctrl.PCwrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_JR: begin
                ctrl.AluSrcA = 1'b1;
                ctrl.PCwrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_RTE: begin
                ctrl.PCSource = PCS_EPC;
                ctrl.PCwrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            S_EXC_EPC: begin
                ctrl.AluSrcB    = SRCB_FOUR;
                ctrl.ALUControl = ALU_SUB;
                ctrl.EPCWrite   = 1'b1;
                state_next      = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                ctrl.IorD      = 1'b1;
                ctrl.Exception = code_reg;
                ctrl.MemRead   = wait_done;
                if (wait_done) state_next = S_EXC_PC;
            end
            S_EXC_PC: begin
                ctrl.PCSource = PCS_VECTOR;
                ctrl.PCwrite  = 1'b1;
                state_next    = S_FETCH;
            end
            default: state_next = S_RESET;
        endcase
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM that drives every control input of the multicycle MIPS datapath (PC, memory, IR, register bank, ALU, shift register, EPC, muxes).
- Consumes OPCODE/FUNCT from the instruction register and ALU flags. It is the sequencing end of the datapath control interface.
- Implements fetch/decode/execute/writeback plus opcode and overflow exception entry.

Parameters:
- MEM_WAIT, 2, cycles from address valid to Memoria data valid (1..7).
- EXC_OPCODE_VEC, 4'd1, Exception code for invalid opcode.
- EXC_OVF_VEC, 4'd2, Exception code for overflow.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OPCODE  in  6  IR[31:26].
- FUNCT  in  6  IR[5:0].
- Overflow  in  1  ALU overflow flag.
- Zero  in  1  ALU zero flag.
- PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA, EPCWrite, IorD, WriteSrc  out  1 each  datapath strobes/selects.
- ALUControl  out  3  000 passA, 001 add, 010 sub, 011 and.
- ShiftControl  out  3  000 nop, 001 load, 010 sll, 011 srl.
- AluSrcB  out  4  0 B, 1 const 4, 2 SignExt, 3 SignExt<<2.
- PCSource  out  4  0 ALUResult, 1 ALUout, 2 jump target, 3 EPC, 4 exception vector byte (MDR[7:0]).
- Exception  out  4  0 none, else vector code driving the exception-address mux.
- state_dbg  out  5  current state encoding.

Behaviour:
- reset low (async): state=S_RESET; all outputs 0.
- S_RESET lasts exactly one cycle after release, then S_FETCH.
- Outputs are pure functions of the state register (Moore), plus the Zero-qualified PCwrite in S_BRANCH.
- Any output not listed for a state is 0.
- S_FETCH: IorD=0; held MEM_WAIT cycles using a 3-bit wait counter cleared on entry.
- S_IR: IRWrite=1; ALU computes PC+4 (AluSrcA=0, AluSrcB=1, ALUControl=001); PCSource=0; PCwrite=1.
- S_DECODE: ALUout<=PC+(SignExt<<2) (AluSrcB=3, add). Dispatch on OPCODE/FUNCT:
  - R-type add(0x20)/sub(0x22)/and(0x24) -> S_R_ALU.
  - sll(0x00)/srl(0x02) -> S_SH_LD.
  - jr(0x08) -> S_JR.
  - rte(0x13) -> S_RTE.
  - break(0x0D) -> S_HALT.
  - addi(0x08) -> S_ADDI.
  - lw(0x23)/sw(0x2B) -> S_MADDR.
  - beq(0x04)/bne(0x05) -> S_BRANCH.
  - j(0x02) -> S_JUMP.
  - Any other OPCODE, or R-type with any other FUNCT -> S_EXC_EPC, code EXC_OPCODE_VEC.
- S_R_ALU: AluSrcA=1, AluSrcB=0, ALUControl per FUNCT. Next S_R_WB.
- S_R_WB: RegDest=1, RegWrite=1, WriteSrc=0, MemToReg=0. Next S_FETCH.
- S_SH_LD (ShiftControl=001) -> S_SH_OP (010 or 011) -> S_SH_WB. S_SH_WB: WriteSrc=1, RegDest=1, RegWrite=1.
- S_ADDI: AluSrcA=1, AluSrcB=2, add. Next S_I_WB (RegDest=0, RegWrite=1).
- S_MADDR: A+SignExt into ALUout. Next S_LW_WAIT (lw) or S_SW (sw).
- S_LW_WAIT: IorD=1, Exception=0, MEM_WAIT cycles, then MemRead=1 for one cycle. Next S_LW_WB (MemToReg=1, RegWrite=1, RegDest=0).
- S_SW: IorD=1, MemWrite=1 for one cycle. Next S_FETCH.
- S_BRANCH: AluSrcA=1, AluSrcB=0, sub; PCSource=1.
  - PCwrite = Zero for beq; PCwrite = ~Zero for bne.
  - Next S_FETCH.
- S_JUMP: PCSource=2, PCwrite=1.
- S_JR: AluSrcA=1, ALUControl=000, PCSource=0, PCwrite=1.
- S_RTE: PCSource=3, PCwrite=1.
- S_HALT: terminal; only reset exits.
- Overflow: sampled in S_R_ALU/S_ADDI (add/sub only). If set and OVERFLOW_EXC_EN is defined, go to S_EXC_EPC with code EXC_OVF_VEC instead of writeback.
- S_EXC_EPC: ALU computes PC-4 (AluSrcA=0, AluSrcB=1, sub); EPCWrite=1. A 4-bit code register latches the vector code.
- S_EXC_WAIT: IorD=1, Exception=code, MEM_WAIT cycles, then MemRead=1.
- S_EXC_PC: PCSource=4, PCwrite=1, Exception=0. Next S_FETCH.
- Every state writes at most one architectural register per cycle; no output glitch across state boundaries beyond state-register skew.

Optional Feature:
- Macro: OVERFLOW_EXC_EN.
- Defined: overflow on add/sub/addi traps as above; result is not written.
- Undefined: Overflow port ignored; result written normally; EXC_OVF_VEC unused.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum;
  - opcode/funct localparams;
  - ALUControl, ShiftControl, AluSrcB and PCSource encodings;
  - exception codes.
- Sub-module: mem_wait_counter (load, done, MEM_WAIT-parameterized), reused by S_FETCH, S_LW_WAIT and S_EXC_WAIT.

Test Plan:
- reset low mid-S_LW_WAIT -> all outputs 0 immediately; after release, S_RESET for 1 cycle, S_FETCH for 2 cycles, then IRWrite=1 and PCwrite=1 in the same cycle.
- OPCODE=0, FUNCT=0x20 -> sequence FETCH(2)/IR/DECODE/R_ALU(ALUControl=001)/R_WB(RegDest=1, RegWrite=1): 6 cycles total.
- OPCODE=0x04, Zero=0 -> no PCwrite in S_BRANCH. OPCODE=0x05, Zero=0 -> PCwrite=1 with PCSource=1.
- OPCODE=0x3F -> EPCWrite=1 with ALUControl=010, then Exception=1 for 2 cycles, MemRead=1, then PCSource=4 with PCwrite=1.
- OPCODE=0x08 with Overflow=1 -> with OVERFLOW_EXC_EN: Exception=2 path and RegWrite never asserted; without it: S_I_WB with RegWrite=1.
- OPCODE=0x2B -> exactly one MemWrite=1 cycle with IorD=1. FUNCT=0x0D R-type -> state_dbg stays at S_HALT indefinitely with all strobes 0.
